vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates horizontal/vertical counters, sync, blanking and pixel coordinates for any mode, using a pixel-clock enable derived from the system clock.
- A configurable pipeline delay aligns sync/DISP with colour from a fixed-latency pixel source (text RAM + font ROM), and colour is forced to zero outside active video.
- Sits between the text renderer and the DAC pins.

Parameters:
- H_VA, 640: active pixels per line.
- H_FP, 16: horizontal front porch (pixels).
- H_SP, 96: horizontal sync width.
- H_BP, 48: horizontal back porch.
- V_VA, 480: active lines.
- V_FP, 10: vertical front porch (lines).
- V_SP, 2: vertical sync width.
- V_BP, 33: vertical back porch.
- HS_POL, 0: active level of VGA_HS (0 = active low).
- VS_POL, 0: active level of VGA_VS.
- DIV, 2: CLK cycles per pixel, >=1.
- PIPE, 2: pixel ticks of latency of the external colour source, 0..8.
- CW, 8: colour channel width.
- CNT_W, 10: counter/coordinate width. Must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- CLK, in, 1: system clock.
- RES, in, 1: reset, asynchronous, active-high.
- EN, in, 1: timing enable.
- C_R, C_G, C_B, in, CW each: pixel colour for the coordinate issued PIPE ticks earlier.
- PIX_EN, out, 1: one-CLK pulse per pixel tick.
- X, Y, out, CNT_W each: coordinate being requested (front end).
- REQ, out, 1: X/Y are inside the active area.
- LINE_START, out, 1: pulse at h=0 of every line.
- FRAME_START, out, 1: pulse at h=0, v=0.
- VGA_HS, VGA_VS, out, 1 each: sync outputs, aligned to colour.
- DISP, out, 1: active video at the pins.
- VGA_R, VGA_G, VGA_B, out, CW each: gated colour.

Behaviour:
- H_TOTAL = H_VA+H_FP+H_SP+H_BP; V_TOTAL likewise.
- Region order per line: active [0,H_VA), then FP, then sync [H_VA+H_FP, H_VA+H_FP+H_SP), then BP. Lines follow the same order.
- Divider: counts 0..DIV-1 on CLK while EN=1. PIX_EN=1 on the cycle the count equals DIV-1. DIV=1 gives PIX_EN=1 continuously while EN=1.
- On PIX_EN, h increments. When h=H_TOTAL-1, h wraps to 0 and v increments. When v=V_TOTAL-1 and h=H_TOTAL-1, both wrap to 0.
- Counters change only on PIX_EN.
- Front end is a combinational function of the registered h and v:
  - REQ = (h<H_VA)&&(v<V_VA).
  - X = REQ?h:0; Y = REQ?v:0.
  - LINE_START = PIX_EN&&h==0; FRAME_START = PIX_EN&&h==0&&v==0.
- Delay line: PIPE-stage shift register of {hs_raw, vs_raw, REQ}, advanced only on PIX_EN. PIPE=0 means no stages.
- Output register, updated on PIX_EN:
  - VGA_HS/VGA_VS = delayed raw sync XNOR polarity (raw sync=1 gives the active level).
  - DISP = delayed REQ.
  - VGA_R/G/B = delayed REQ ? C_* : 0.
- Net latency: position issued at pixel tick t appears on the pins after tick t+PIPE. C_* is sampled at tick t+PIPE.
- Outputs hold between PIX_EN pulses.
- Reset values (RES=1, asynchronous):
  - Divider, h and v = 0; pipeline cleared.
  - PIX_EN=0, REQ=1 (combinational at h=v=0), X=Y=0.
  - VGA_HS = ~HS_POL, VGA_VS = ~VS_POL (inactive).
  - DISP=0; VGA_R/G/B=0; LINE_START=FRAME_START=0.
- EN=0 (synchronous): next CLK returns everything to reset values, and holds them there while EN=0.
- First PIX_EN after EN rises is issued DIV cycles later and is for position (0,0); it asserts FRAME_START.
- RES or EN drop mid-frame: the partial frame is abandoned with no glitch beyond the reset values; the restart is a clean frame.
- No combinational path from C_* to any output.

Test Plan:
- Reset, then run defaults (DIV=2): PIX_EN period = 2 CLK; FRAME_START period = 840000 CLK; LINE_START period = 1600 CLK.
- Defaults: VGA_HS low for exactly 96 ticks starting at h=656 (+PIPE ticks); VGA_VS low for exactly 2 lines starting at v=490; both high elsewhere.
- Drive C_R = X[7:0] with a PIPE=2 behavioural source: VGA_R equals the expected pixel value at every DISP=1 tick; VGA_R/G/B = 0 at h=640..799 and at v>=480.
- HS_POL=1, VS_POL=1, DIV=1, PIPE=0, tiny mode (H_VA=4, H_FP=1, H_SP=2, H_BP=1, V_VA=2, V_FP=V_SP=V_BP=1): H_TOTAL=8, V_TOTAL=5, frame = 40 CLK; HS high at h=5,6; DISP coincides with REQ after one register stage.
- EN deasserted at h=300, v=100, then reasserted: outputs hold reset values while EN=0; after 2 CLK, FRAME_START fires with X=0, Y=0.
- RES pulse asserted asynchronously mid-line (not on a CLK edge): VGA_HS/VS go inactive, DISP=0 and colour=0 immediately; after release, timing restarts from (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing. It derives a pixel-clock
// enable from CLK, runs the h/v counters, issues request coordinates to a
// fixed-latency colour source, and delays sync/blanking by the same latency
// so the pins see sync, DISP and gated colour for one position together.
module vga_timing_gen #(
  parameter int H_VA   = 640,
  parameter int H_FP   = 16,
  parameter int H_SP   = 96,
  parameter int H_BP   = 48,
  parameter int V_VA   = 480,
  parameter int V_FP   = 10,
  parameter int V_SP   = 2,
  parameter int V_BP   = 33,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int DIV    = 2,
  parameter int PIPE   = 2,
  parameter int CW     = 8,
  parameter int CNT_W  = 10
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             EN,
  input  logic [CW-1:0]    C_R,
  input  logic [CW-1:0]    C_G,
  input  logic [CW-1:0]    C_B,
  output logic             PIX_EN,
  output logic [CNT_W-1:0] X,
  output logic [CNT_W-1:0] Y,
  output logic             REQ,
  output logic             LINE_START,
  output logic             FRAME_START,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             DISP,
  output logic [CW-1:0]    VGA_R,
  output logic [CW-1:0]    VGA_G,
  output logic [CW-1:0]    VGA_B
);

  localparam int H_TOTAL = H_VA + H_FP + H_SP + H_BP;
  localparam int V_TOTAL = V_VA + V_FP + V_SP + V_BP;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VA_C   = CNT_W'(H_VA);
  localparam logic [CNT_W-1:0] V_VA_C   = CNT_W'(V_VA);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VA + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VA + H_FP + H_SP);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VA + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VA + V_FP + V_SP);
  localparam logic             HS_ACT   = (HS_POL != 0);
  localparam logic             VS_ACT   = (VS_POL != 0);

  // One delay-line entry: raw sync flags and active-area flag for a position.
  typedef struct packed {
    logic hs;
    logic vs;
    logic req;
  } tap_t;

  logic             run;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  tap_t             tap_in;
  tap_t             tap_out;

  // Divider: 'run' delays the start by one CLK so the first tick lands DIV cycles after EN
  always_ff @(posedge CLK or posedge RES) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (RES) begin
      run     <= 1'b0;
      div_cnt <= '0;
    end else if (!EN) begin
      run     <= 1'b0;
      div_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (run) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  assign PIX_EN = run && (div_cnt == DIV_LAST);

  // Raster counters: advance one position per pixel tick, wrap line then frame
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      h <= '0;
      v <= '0;
    end else if (!EN) begin
      h <= '0;
      v <= '0;
    end else if (PIX_EN) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + CNT_W'(1);
      end else begin
        h <= h + CNT_W'(1);
      end
    end
  end

  // Front end: request coordinates, line/frame markers and raw sync for this position
  always_comb begin
    // NOTE: defaults first so no branch leaves a signal unassigned (no latch).
    X           = '0;
    Y           = '0;
    REQ         = (h < H_VA_C) && (v < V_VA_C);
    LINE_START  = PIX_EN && (h == '0);
    FRAME_START = PIX_EN && (h == '0) && (v == '0);
    tap_in.hs   = (h >= HS_BEG) && (h < HS_END);
    tap_in.vs   = (v >= VS_BEG) && (v < VS_END);
    tap_in.req  = REQ;
    if (REQ) begin
      X = h;
      Y = v;
    end
  end

  generate
    if (PIPE == 0) begin : g_no_pipe
      assign tap_out = tap_in;
    end else begin : g_pipe
      tap_t stage [PIPE];

      // Delay line matching the colour source latency, stepped on pixel ticks
      always_ff @(posedge CLK or posedge RES) begin
        // NOTE: only a few flops, so it is cleared to make every restart start blank.
        if (RES) begin
          for (int i = 0; i < PIPE; i++) stage[i] <= '0;
        end else if (!EN) begin
          for (int i = 0; i < PIPE; i++) stage[i] <= '0;
        end else if (PIX_EN) begin
          stage[0] <= tap_in;
          for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
        end
      end

      assign tap_out = stage[PIPE-1];
    end
  endgenerate

  // Pin register: polarity-adjusted sync, DISP and colour gated to black when blanked
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      VGA_HS <= ~HS_ACT;
      VGA_VS <= ~VS_ACT;
      DISP   <= 1'b0;
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
    end else if (!EN) begin
      VGA_HS <= ~HS_ACT;
      VGA_VS <= ~VS_ACT;
      DISP   <= 1'b0;
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
    end else if (PIX_EN) begin
      VGA_HS <= ~(tap_out.hs ^ HS_ACT);
      VGA_VS <= ~(tap_out.vs ^ VS_ACT);
      DISP   <= tap_out.req;
      VGA_R  <= tap_out.req ? C_R : '0;
      VGA_G  <= tap_out.req ? C_G : '0;
      VGA_B  <= tap_out.req ? C_B : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: DUT A runs standard 640-pixel lines with a short frame,
// DIV=2, PIPE=2, active-low sync, random EN drops and an async reset pulse.
// DUT B runs the tiny 8x5 mode with DIV=1, PIPE=0 and active-high sync.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int A_HVA = 640, A_HFP = 16, A_HSP = 96, A_HBP = 48;
  localparam int A_VVA = 6,   A_VFP = 1,  A_VSP = 2,  A_VBP = 1;
  localparam int A_DIV = 2,   A_PIPE = 2;
  localparam int A_HT  = A_HVA + A_HFP + A_HSP + A_HBP;
  localparam int A_VT  = A_VVA + A_VFP + A_VSP + A_VBP;

  localparam int B_HVA = 4, B_HFP = 1, B_HSP = 2, B_HBP = 1;
  localparam int B_VVA = 2, B_VFP = 1, B_VSP = 1, B_VBP = 1;
  localparam int B_HT  = 8, B_VT = 5;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       disp;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pins_t;

  localparam pins_t INACT_A = '{hs: 1'b1, vs: 1'b1, disp: 1'b0, r: 8'h0, g: 8'h0, b: 8'h0};
  localparam pins_t INACT_B = '{hs: 1'b0, vs: 1'b0, disp: 1'b0, r: 8'h0, g: 8'h0, b: 8'h0};

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected front-end bundle {PIX_EN, REQ, LINE_START, FRAME_START, X, Y}.
  function automatic logic [23:0] front_exp(input bit pix, input int h, input int v,
                                            input int hva, input int vva);
    logic       req;
    logic [9:0] xv, yv;
    req = (h < hva) && (v < vva);
    xv  = req ? 10'(h) : 10'd0;
    yv  = req ? 10'(v) : 10'd0;
    return {pix, req, pix && (h == 0), pix && (h == 0) && (v == 0), xv, yv};
  endfunction

  // Pin values mode A must show for position (h,v) with source colour {h[7:0], g, b}.
  function automatic pins_t pins_exp_a(input int h, input int v, input logic [7:0] g,
                                       input logic [7:0] b);
    pins_t       e;
    logic        req;
    logic [31:0] hv;
    hv     = h;
    req    = (h < A_HVA) && (v < A_VVA);
    e.hs   = !((h >= A_HVA + A_HFP) && (h < A_HVA + A_HFP + A_HSP));
    e.vs   = !((v >= A_VVA + A_VFP) && (v < A_VVA + A_VFP + A_VSP));
    e.disp = req;
    e.r    = req ? hv[7:0] : 8'h0;
    e.g    = req ? g : 8'h0;
    e.b    = req ? b : 8'h0;
    return e;
  endfunction

  // ---------------- DUT A ----------------
  logic       res_a, en_a;
  logic [7:0] cr_a, cg_a, cb_a;
  logic       pix_a, req_a, ls_a, fs_a, hs_a, vs_a, disp_a;
  logic [9:0] x_a, y_a;
  logic [7:0] r_a, g_a, b_a;
  pins_t      pins_a;
  assign pins_a = {hs_a, vs_a, disp_a, r_a, g_a, b_a};

  vga_timing_gen #(
    .H_VA(A_HVA), .H_FP(A_HFP), .H_SP(A_HSP), .H_BP(A_HBP),
    .V_VA(A_VVA), .V_FP(A_VFP), .V_SP(A_VSP), .V_BP(A_VBP),
    .HS_POL(0), .VS_POL(0), .DIV(A_DIV), .PIPE(A_PIPE), .CW(8), .CNT_W(10)
  ) dut_a (
    .CLK(CLK), .RES(res_a), .EN(en_a),
    .C_R(cr_a), .C_G(cg_a), .C_B(cb_a),
    .PIX_EN(pix_a), .X(x_a), .Y(y_a), .REQ(req_a),
    .LINE_START(ls_a), .FRAME_START(fs_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .DISP(disp_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a)
  );

  // ---------------- DUT B ----------------
  logic       res_b, en_b;
  logic [7:0] cr_b, cg_b, cb_b;
  logic       pix_b, req_b, ls_b, fs_b, hs_b, vs_b, disp_b;
  logic [9:0] x_b, y_b;
  logic [7:0] r_b, g_b, b_b;
  pins_t      pins_b;
  assign pins_b = {hs_b, vs_b, disp_b, r_b, g_b, b_b};

  vga_timing_gen #(
    .H_VA(B_HVA), .H_FP(B_HFP), .H_SP(B_HSP), .H_BP(B_HBP),
    .V_VA(B_VVA), .V_FP(B_VFP), .V_SP(B_VSP), .V_BP(B_VBP),
    .HS_POL(1), .VS_POL(1), .DIV(1), .PIPE(0), .CW(8), .CNT_W(10)
  ) dut_b (
    .CLK(CLK), .RES(res_b), .EN(en_b),
    .C_R(cr_b), .C_G(cg_b), .C_B(cb_b),
    .PIX_EN(pix_b), .X(x_b), .Y(y_b), .REQ(req_b),
    .LINE_START(ls_b), .FRAME_START(fs_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .DISP(disp_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
  );

  // Scoreboard shared between the mode-A stimulus and its pin monitor.
  pins_t       exp_q[$];
  logic [23:0] src_q[$];
  bit          restart_a = 1'b1;
  bit          done_b    = 1'b0;

  // Pin monitor A: on every DUT tick take the next expected position (after PIPE ticks).
  int    mon_t      = 0;
  pins_t cur_a      = INACT_A;
  bit    pix_prev_a = 1'b0;
  always @(negedge CLK) begin
    #2;
    if (restart_a) begin
      mon_t = 0;
      cur_a = INACT_A;
    end else if (pix_prev_a) begin
      mon_t++;
      if (mon_t > A_PIPE) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: DUT tick %0d with no expected entry (t=%0t)", mon_t, $time);
        end else begin
          cur_a = exp_q.pop_front();
        end
      end
    end
    check("pins_a", pins_a, cur_a);
    pix_prev_a = pix_a;
  end

  // Stimulus and reference model for mode A.
  initial begin : stim_a
    int          en_cycles, p, h, v, cyc, last_ls, last_fs, last_pix, drop_left;
    bit          en_applied, res_applied, did_drop, did_rst, pix;
    logic [7:0]  g, b;
    logic [23:0] c;

    res_a = 1'b1; en_a = 1'b1; cr_a = '0; cg_a = '0; cb_a = '0;
    repeat (3) @(negedge CLK);
    check("rst_front_a", {pix_a, req_a, ls_a, fs_a, x_a, y_a}, {1'b0, 1'b1, 2'b00, 20'd0});
    check("rst_pins_a", pins_a, INACT_A);
    res_a = 1'b0;
    en_applied = 1'b1; res_applied = 1'b0;
    en_cycles = 0; cyc = 0; drop_left = 0; did_drop = 1'b0; did_rst = 1'b0;
    last_ls = -1; last_fs = -1; last_pix = -1;

    for (int i = 0; i < 52000; i++) begin
      @(negedge CLK);
      cyc++;
      if (res_applied || !en_applied) begin
        en_cycles = 0;
        exp_q.delete();
        src_q.delete();
        restart_a = 1'b1;
        last_ls = -1; last_fs = -1; last_pix = -1;
      end else begin
        en_cycles++;
        restart_a = 1'b0;
      end

      pix = (en_cycles > 0) && (en_cycles % A_DIV == 0);
      p   = (en_cycles > 0) ? (en_cycles - 1) / A_DIV : 0;
      h   = p % A_HT;
      v   = (p / A_HT) % A_VT;
      check("front_a", {pix_a, req_a, ls_a, fs_a, x_a, y_a}, front_exp(pix, h, v, A_HVA, A_VVA));
      if (en_cycles == A_DIV)
        check("first_tick_a", {fs_a, x_a, y_a}, {1'b1, 20'd0});

      if (pix_a) begin
        if (last_pix >= 0) check("pix_period_a", cyc - last_pix, A_DIV);
        last_pix = cyc;
      end
      if (ls_a) begin
        if (last_ls >= 0) check("line_period_a", cyc - last_ls, A_HT * A_DIV);
        last_ls = cyc;
      end
      if (fs_a) begin
        if (last_fs >= 0) check("frame_period_a", cyc - last_fs, A_HT * A_VT * A_DIV);
        last_fs = cyc;
      end

      // Behavioural colour source: answers each request PIPE ticks later, junk in between.
      if (pix) begin
        g = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        c = {x_a[7:0], g, b};
        src_q.push_back(c);
        exp_q.push_back(pins_exp_a(h, v, g, b));
      end
      if (pix && src_q.size() > A_PIPE) begin
        {cr_a, cg_a, cb_a} = src_q.pop_front();
      end else begin
        {cr_a, cg_a, cb_a} = 24'($urandom());
      end

      if (drop_left == 0 && cyc < 17000) begin
        if (!did_drop && pix && h == 300 && v == 3) begin
          drop_left = 3;
          did_drop  = 1'b1;
        end else if ($urandom_range(0, 7999) == 0) begin
          drop_left = $urandom_range(1, 4);
        end
      end
      if (drop_left > 0) begin
        en_a = 1'b0;
        drop_left--;
      end else begin
        en_a = 1'b1;
      end
      en_applied = en_a;

      if (res_a) begin
        #3;
        res_a = 1'b0;
      end
      res_applied = 1'b0;
      if (!did_rst && cyc > 17000 && pix && h == 100 && v == 2 && en_a) begin
        did_rst = 1'b1;
        #3;
        res_a = 1'b1;
        #1;
        check("async_rst_pins_a", pins_a, INACT_A);
        check("async_rst_front_a", {pix_a, req_a, ls_a, fs_a, x_a, y_a}, {1'b0, 1'b1, 2'b00, 20'd0});
        res_applied = 1'b1;
      end
    end

    if (!done_b) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_b: mode B sequence did not complete, got 0, expected 1");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Directed run of the tiny mode B, checked cycle by cycle against tick arithmetic.
  initial begin : stim_b
    int         ec, p, h, v, q, hq, vq, last_fs, last_ls, cyc;
    logic       reqq;
    logic [23:0] prev_c;
    pins_t      e;

    res_b = 1'b1; en_b = 1'b0; {cr_b, cg_b, cb_b} = '0;
    repeat (2) @(negedge CLK);
    check("rst_front_b", {pix_b, req_b, ls_b, fs_b, x_b, y_b}, {1'b0, 1'b1, 2'b00, 20'd0});
    check("rst_pins_b", pins_b, INACT_B);
    res_b = 1'b0; en_b = 1'b1;
    prev_c = 24'($urandom());
    {cr_b, cg_b, cb_b} = prev_c;
    ec = 0; cyc = 0; last_fs = -1; last_ls = -1;

    for (int i = 0; i < 130; i++) begin
      @(negedge CLK);
      ec++;
      cyc++;
      p = ec - 1;
      h = p % B_HT;
      v = (p / B_HT) % B_VT;
      check("front_b", {pix_b, req_b, ls_b, fs_b, x_b, y_b}, front_exp(1'b1, h, v, B_HVA, B_VVA));

      if (ec >= 2) begin
        q      = ec - 2;
        hq     = q % B_HT;
        vq     = (q / B_HT) % B_VT;
        reqq   = (hq < B_HVA) && (vq < B_VVA);
        e.hs   = (hq == 5) || (hq == 6);
        e.vs   = (vq == 3);
        e.disp = reqq;
        {e.r, e.g, e.b} = reqq ? prev_c : 24'd0;
      end else begin
        e = INACT_B;
      end
      check("pins_b", pins_b, e);

      if (fs_b) begin
        if (last_fs >= 0) check("frame_period_b", cyc - last_fs, B_HT * B_VT);
        last_fs = cyc;
      end
      if (ls_b) begin
        if (last_ls >= 0) check("line_period_b", cyc - last_ls, B_HT);
        last_ls = cyc;
      end

      prev_c = 24'($urandom());
      {cr_b, cg_b, cb_b} = prev_c;
    end
    done_b = 1'b1;
  end

endmodule
